rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  Registered, parametrised N-way arbiter with a valid/ready grant handshake; fixed-priority or round-robin.
//  Successor to the combinational tree arbiter. Adds a fairness pointer, grant locking for multi-beat
//  transfers, and grant stability under backpressure.
//  Sits in front of shared resources: issue ports, the bus master mux and the writeback port.
// PARAMETERS
//  WIDTH         64   number of requesters; power of two, >=2
//  ONE_HOT_CODE  1    1: grant_o is one-hot [WIDTH-1:0]; 0: grant_o is an index [$clog2(WIDTH)-1:0]
//  ROUND_ROBIN   1    1: rotating priority; 0: fixed priority, highest index wins
// PORTS
//  clk_i          in   1      clock; all state updates on posedge
//  rst_i          in   1      synchronous reset, active-high
//  request_i      in   WIDTH  per-requester request, level-sensitive
//  lock_i         in   1      sampled only at handshake; 1 = keep the same requester for the next grant
//  grant_ready_i  in   1      consumer accepts the current grant
//  grant_valid_o  out  1      grant_o is valid
//  grant_o        out  WIDTH or $clog2(WIDTH)  winning requester (encoding per ONE_HOT_CODE)
//  locked_o       out  1      the current grant was issued under lock
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge) gives: grant_valid_o=0, grant_o=0, locked_o=0, ptr=0, state=IDLE.
//    Reset mid-offer drops the grant immediately; no handshake is reported.
//  - Handshake (hs) = grant_valid_o & grant_ready_i.
//  - Winner computation, combinational from request_i and ptr:
//    - masked = request_i & ((1<<ptr)-1).
//    - winner = highest set index of masked if masked!=0, else highest set index of request_i.
//    - With ROUND_ROBIN=0, the mask is forced to 0, so the highest index always wins.
//  - State IDLE (grant_valid_o=0):
//    - If |request_i, load winner into the grant register and go to OFFER.
//    - Latency is 1 cycle from request to grant_valid_o.
//  - State OFFER (grant_valid_o=1):
//    - grant_o and locked_o stay stable until hs, even if the granted request drops (no retraction).
//    - On hs with ROUND_ROBIN=1 and lock_i=0: ptr <= granted index, so the granted requester gets lowest priority.
//    - On hs with lock_i=1: ptr is unchanged.
//    - Next grant at hs, back-to-back with no bubble:
//      - lock_i=1 and request_i[granted]=1: re-offer the same index with locked_o=1.
//      - otherwise, if |request_i: offer the winner, computed with the updated ptr, with locked_o=0.
//      - otherwise: go to IDLE, grant_valid_o=0.
//  - Throughput: one grant per cycle when grant_ready_i is held at 1.
//  - Under ONE_HOT_CODE=1, grant_o is exactly one-hot while valid and 0 while invalid.
//    Under ONE_HOT_CODE=0, grant_o holds its last value while invalid and reads 0 after reset.
//  - Boundary cases:
//    - If lock_i is asserted but the locked requester has dropped its request, the lock is released and normal arbitration applies.
//    - ptr wrap: ptr=0 gives an empty mask, which falls back to full fixed priority.
//    - Simultaneous requests all get service within WIDTH handshakes when ROUND_ROBIN=1.
// STRUCTURE
//  - Shared package arbiter_pkg.vh: localparam state encoding ARB_IDLE=1'b0, ARB_OFFER=1'b1;
//    the IDX_W=$clog2(WIDTH) helper macro.
//  - Sub-module: two instances of the existing fixed-priority tree Arbiter (ONE_HOT_CODE=0),
//    one on the masked vector and one on the full vector. A final mux selects between them on |masked.
//  - Local logic: ptr register, state flop, grant/locked registers, index-to-one-hot decoder at the output.
// TESTING (WIDTH=8 unless noted)
//  1. Reset check: rst_i=1 with request_i=8'hFF
//     -> grant_valid_o=0, grant_o=0, locked_o=0. One cycle after release -> grant index 7.
//  2. Round-robin: request_i=8'b1000_0101 held, grant_ready_i=1
//     -> grants 7,2,0,7,2,0 on consecutive cycles, with no bubbles.
//  3. Backpressure: request_i=8'h10, grant_ready_i=0 for 5 cycles, request drops at cycle 2
//     -> grant_o=4 stays stable and valid until ready=1, then IDLE.
//  4. Lock: request_i=8'b0000_0011, lock_i=1 on the first two handshakes
//     -> grants 1,1(locked_o=1),1(locked_o=1),0.
//     Then drop request_i[1] while lock_i=1 -> next grant 0 with locked_o=0.
//  5. Fixed mode: ROUND_ROBIN=0, request_i=8'b1000_0001, ready=1
//     -> grant 7 every cycle; requester 0 is starved.
//  6. Encoding: ONE_HOT_CODE=0, WIDTH=64, request_i=1<<37 -> grant_o=6'd37.
//     Then reset mid-offer -> valid drops to 0 at that edge.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the registered round-robin / fixed-priority arbiter.
//   arb_state_e : grant-offer state (IDLE = nothing offered, OFFER = grant valid)
//   arb_idx_w   : index width for a given requester count
package rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  function automatic int arb_idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_tree.sv
// Fixed-priority tree arbiter: returns the highest set index of req.
// Built as a balanced binary tree of compare nodes, so the depth grows with
// log2(WIDTH) rather than WIDTH.
// Ports:
//   req   in  WIDTH          request vector
//   found out 1              at least one bit of req is set
//   idx   out $clog2(WIDTH)  highest set index (0 when found=0)
module rr_arbiter_tree
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]         req,
  output logic                     found,
  output logic [$clog2(WIDTH)-1:0] idx
);

  localparam int IDX_W = arb_idx_w(WIDTH);

  // Level 0 holds the leaves; level l holds WIDTH>>l nodes. In each node the
  // odd (upper) child carries the higher indices, so it wins when valid.
  for (genvar l = 0; l <= IDX_W; l++) begin : lvl_g
    localparam int N = WIDTH >> l;
    logic [N-1:0]     node_vld;
    logic [IDX_W-1:0] node_idx [N];

    if (l == 0) begin : leaf_g
      for (genvar i = 0; i < N; i++) begin : n_g
        assign node_vld[i] = req[i];
        assign node_idx[i] = IDX_W'(i);
      end
    end else begin : node_g
      for (genvar i = 0; i < N; i++) begin : n_g
        assign node_vld[i] = lvl_g[l-1].node_vld[2*i] | lvl_g[l-1].node_vld[2*i+1];
        assign node_idx[i] = lvl_g[l-1].node_vld[2*i+1] ? lvl_g[l-1].node_idx[2*i+1]
                                                        : lvl_g[l-1].node_idx[2*i];
      end
    end
  end

  assign found = lvl_g[IDX_W].node_vld[0];
  assign idx   = lvl_g[IDX_W].node_idx[0];

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter with a valid/ready grant handshake.
// Rotating (round-robin) or fixed (highest index wins) priority, grant locking
// for multi-beat transfers, and a grant that never changes while it is being
// offered and not yet accepted.
// Ports:
//   clk_i          in   1       clock
//   rst_i          in   1       synchronous reset, active-high
//   request_i      in   WIDTH   per-requester level-sensitive request
//   lock_i         in   1       at handshake: keep the same requester next
//   grant_ready_i  in   1       consumer accepts the offered grant
//   grant_valid_o  out  1       grant_o is valid
//   grant_o        out  WIDTH (one-hot) or $clog2(WIDTH) (index)
//   locked_o       out  1       the offered grant was issued under lock
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int ONE_HOT_CODE = 1,
  parameter int ROUND_ROBIN  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     request_i,
  input  logic                 lock_i,
  input  logic                 grant_ready_i,
  output logic                 grant_valid_o,
  output logic [((ONE_HOT_CODE != 0) ? WIDTH : $clog2(WIDTH))-1:0] grant_o,
  output logic                 locked_o
);

  localparam int IDX_W = arb_idx_w(WIDTH);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             locked_q, locked_d;

  logic             hs;
  logic             lock_hold;
  logic [WIDTH-1:0] prio_mask;
  logic [WIDTH-1:0] masked_req;
  logic             masked_any, full_any;
  logic [IDX_W-1:0] masked_idx, full_idx, winner_idx;

  assign hs = (state_q == ARB_OFFER) && grant_ready_i;

  // The pointer update is computed ahead of arbitration so a back-to-back
  // grant at handshake already sees the granted requester demoted.
  always_comb begin
    ptr_d = ptr_q;
    if (hs && (ROUND_ROBIN != 0) && !lock_i) begin
      ptr_d = grant_idx_q;
    end
  end

  // Requesters below the pointer have priority over the rest; ptr=0 yields an
  // empty mask and therefore plain fixed priority.
  always_comb begin
    prio_mask = '0;
    if (ROUND_ROBIN != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        prio_mask[i] = (i < int'(ptr_d));
      end
    end
  end

  assign masked_req = request_i & prio_mask;

  rr_arbiter_tree #(
    .WIDTH (WIDTH)
  ) u_masked_tree (
    .req   (masked_req),
    .found (masked_any),
    .idx   (masked_idx)
  );

  rr_arbiter_tree #(
    .WIDTH (WIDTH)
  ) u_full_tree (
    .req   (request_i),
    .found (full_any),
    .idx   (full_idx)
  );

  assign winner_idx = masked_any ? masked_idx : full_idx;

  // A lock only holds while the locked requester still asks; otherwise it is
  // released and normal arbitration takes over.
  assign lock_hold = lock_i && request_i[grant_idx_q];

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    locked_d    = locked_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (full_any) begin
          grant_idx_d = winner_idx;
          locked_d    = 1'b0;
          state_d     = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (hs) begin
          if (lock_hold) begin
            locked_d = 1'b1;
          end else if (full_any) begin
            grant_idx_d = winner_idx;
            locked_d    = 1'b0;
          end else begin
            locked_d = 1'b0;
            state_d  = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  // ---- registered grant stage ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      locked_q    <= locked_d;
    end
  end

  assign grant_valid_o = (state_q == ARB_OFFER);
  assign locked_o      = locked_q;

  // One-hot output is forced to zero when nothing is offered; the index
  // output simply shows the last granted index.
  if (ONE_HOT_CODE != 0) begin : oh_g
    always_comb begin
      grant_o = '0;
      if (state_q == ARB_OFFER) begin
        grant_o[grant_idx_q] = 1'b1;
      end
    end
  end else begin : idx_g
    assign grant_o = grant_idx_q;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: WIDTH=8, one-hot, round-robin
  logic       a_rst, a_lock, a_rdy, a_vld, a_lkd;
  logic [7:0] a_req, a_gnt;
  // dut 1: WIDTH=8, index, fixed priority
  logic       b_rst, b_lock, b_rdy, b_vld, b_lkd;
  logic [7:0] b_req;
  logic [2:0] b_gnt;
  // dut 2: WIDTH=64, index, round-robin
  logic        c_rst, c_lock, c_rdy, c_vld, c_lkd;
  logic [63:0] c_req;
  logic [5:0]  c_gnt;

  rr_arbiter #(.WIDTH(8), .ONE_HOT_CODE(1), .ROUND_ROBIN(1)) u_a (
    .clk_i(clk), .rst_i(a_rst), .request_i(a_req), .lock_i(a_lock),
    .grant_ready_i(a_rdy), .grant_valid_o(a_vld), .grant_o(a_gnt), .locked_o(a_lkd));

  rr_arbiter #(.WIDTH(8), .ONE_HOT_CODE(0), .ROUND_ROBIN(0)) u_b (
    .clk_i(clk), .rst_i(b_rst), .request_i(b_req), .lock_i(b_lock),
    .grant_ready_i(b_rdy), .grant_valid_o(b_vld), .grant_o(b_gnt), .locked_o(b_lkd));

  rr_arbiter #(.WIDTH(64), .ONE_HOT_CODE(0), .ROUND_ROBIN(1)) u_c (
    .clk_i(clk), .rst_i(c_rst), .request_i(c_req), .lock_i(c_lock),
    .grant_ready_i(c_rdy), .grant_valid_o(c_vld), .grant_o(c_gnt), .locked_o(c_lkd));

  int cfg_w  [3] = '{8, 8, 64};
  bit cfg_rr [3] = '{1'b1, 1'b0, 1'b1};
  bit cfg_oh [3] = '{1'b1, 1'b0, 1'b0};

  // Reference model state: what each arbiter is offering and its fairness point.
  bit m_valid  [3];
  int m_idx    [3];
  bit m_locked [3];
  int m_ptr    [3];

  typedef struct {
    int dut;
    bit valid;
    int idx;
    bit locked;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  // Round-robin: walk downward from just below the pointer, wrapping around,
  // and take the first requester met. Fixed: the highest requester.
  function automatic int pick(int d, logic [63:0] req);
    int w;
    w = cfg_w[d];
    if (!cfg_rr[d]) begin
      for (int i = w - 1; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= w; k++) begin
        int i;
        i = (m_ptr[d] - k + w) % w;
        if (req[i]) return i;
      end
    end
    return 0;
  endfunction

  task automatic cycle(int d, logic [63:0] req, bit lock, bit rdy, bit rst);
    exp_t e;
    int   old;
    if (cfg_w[d] < 64) req = req & ((64'd1 << cfg_w[d]) - 64'd1);
    case (d)
      0: begin a_req = req[7:0]; a_lock = lock; a_rdy = rdy; a_rst = rst; end
      1: begin b_req = req[7:0]; b_lock = lock; b_rdy = rdy; b_rst = rst; end
      default: begin c_req = req; c_lock = lock; c_rdy = rdy; c_rst = rst; end
    endcase
    if (rst) begin
      m_valid[d] = 1'b0; m_idx[d] = 0; m_locked[d] = 1'b0; m_ptr[d] = 0;
    end else if (!m_valid[d]) begin
      if (req != 64'd0) begin
        m_idx[d] = pick(d, req); m_valid[d] = 1'b1; m_locked[d] = 1'b0;
      end
    end else if (rdy) begin
      old = m_idx[d];
      if (cfg_rr[d] && !lock) m_ptr[d] = old;
      if (lock && req[old]) begin
        m_locked[d] = 1'b1;
      end else if (req != 64'd0) begin
        m_idx[d] = pick(d, req); m_locked[d] = 1'b0;
      end else begin
        m_valid[d] = 1'b0; m_locked[d] = 1'b0;
      end
    end
    e.dut = d; e.valid = m_valid[d]; e.idx = m_idx[d]; e.locked = m_locked[d];
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk(string name, int d, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %0h want %0h", name, d, $time, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] act_g, exp_g;
    logic        act_v, act_l;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0: begin act_v = a_vld; act_g = 64'(a_gnt); act_l = a_lkd; end
        1: begin act_v = b_vld; act_g = 64'(b_gnt); act_l = b_lkd; end
        default: begin act_v = c_vld; act_g = 64'(c_gnt); act_l = c_lkd; end
      endcase
      if (cfg_oh[e.dut]) exp_g = e.valid ? (64'd1 << e.idx) : 64'd0;
      else               exp_g = 64'(e.idx);
      chk("grant_valid", e.dut, 64'(act_v), 64'(e.valid));
      chk("grant", e.dut, act_g, exp_g);
      chk("locked", e.dut, 64'(act_l), 64'(e.locked));
    end
  end

  task automatic random_run(int d, int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r = r & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) r = 64'd0;
      cycle(d, r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 49) == 0));
    end
  endtask

  initial begin
    a_rst = 1'b1; a_req = '0; a_lock = 1'b0; a_rdy = 1'b0;
    b_rst = 1'b1; b_req = '0; b_lock = 1'b0; b_rdy = 1'b0;
    c_rst = 1'b1; c_req = '0; c_lock = 1'b0; c_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // dut 0: reset with every request up, then release
    cycle(0, 64'hFF, 0, 0, 1);
    cycle(0, 64'hFF, 0, 0, 0);
    cycle(0, 64'h00, 0, 1, 0);
    // round-robin 7,2,0,... from a fresh pointer
    cycle(0, 64'h00, 0, 0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 64'h85, 0, 1, 0);
    // backpressure: grant 4 held while the request drops
    cycle(0, 64'h00, 0, 0, 1);
    cycle(0, 64'h10, 0, 0, 0);
    cycle(0, 64'h10, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 64'h00, 0, 0, 0);
    cycle(0, 64'h00, 0, 1, 0);
    cycle(0, 64'h00, 0, 0, 0);
    // lock: 1, 1L, 1L, 0, then lock released when requester 1 drops
    cycle(0, 64'h00, 0, 0, 1);
    cycle(0, 64'h03, 1, 1, 0);
    cycle(0, 64'h03, 1, 1, 0);
    cycle(0, 64'h03, 1, 1, 0);
    cycle(0, 64'h03, 0, 1, 0);
    cycle(0, 64'h03, 0, 1, 0);
    cycle(0, 64'h01, 1, 1, 0);
    cycle(0, 64'h00, 0, 1, 0);
    cycle(0, 64'h00, 0, 0, 0);
    random_run(0, 300);
    a_rst = 1'b1; a_req = '0;

    // dut 1: fixed priority starves requester 0
    cycle(1, 64'h00, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 64'h81, 0, 1, 0);
    random_run(1, 300);
    b_rst = 1'b1; b_req = '0;

    // dut 2: wide index encoding, then reset mid-offer
    cycle(2, 64'h0, 0, 0, 1);
    cycle(2, 64'd1 << 37, 0, 0, 0);
    cycle(2, 64'd1 << 37, 0, 0, 0);
    cycle(2, 64'd1 << 37, 0, 0, 1);
    cycle(2, 64'h0, 0, 0, 0);
    random_run(2, 300);
    c_rst = 1'b1; c_req = '0;

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
